// File: rtl/sine_pkg.sv
// Shared constants and state type for the sine generator / period meter pair.
package sine_pkg;

    localparam int DATA_W   = 8;
    localparam int MIDPOINT = 127;

    typedef enum logic {
        SEEK    = 1'b0,
        MEASURE = 1'b1
    } meter_state_t;

endpackage

// File: rtl/sine_hyst_cmp.sv
// Hysteresis comparator: tracks which side of the mid band the waveform is on and flags
// rising crossings. rearm forces the "high" state so a fresh low sample is needed again.
module sine_hyst_cmp #(
    parameter int W     = sine_pkg::DATA_W,
    parameter int HI_TH = sine_pkg::MIDPOINT + 4,
    parameter int LO_TH = sine_pkg::MIDPOINT - 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid,
    input  logic         rearm,
    input  logic [W-1:0] sample,
    output logic         rise_evt
);

    localparam logic [W-1:0] HI_LVL = W'(HI_TH);
    localparam logic [W-1:0] LO_LVL = W'(LO_TH);

    logic hi_q;
    logic above;
    logic below;

    assign above    = (sample >= HI_LVL);
    assign below    = (sample <= LO_LVL);
    assign rise_evt = valid && !hi_q && above;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q <= 1'b1;
        end else if (rearm) begin
            hi_q <= 1'b1;
        end else if (valid) begin
            if (above) begin
                hi_q <= 1'b1;
            end else if (below) begin
                hi_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sine_period_meter.sv
// Period meter for a sampled, mid-scale-centred waveform: counts accepted samples between
// rising hysteresis crossings. Define SINE_METER_PEAK_EN to also report per-period max/min.
//
//  state   | meaning
//  --------+----------------------------------------------------------------
//  SEEK    | waiting for the first rising crossing; no period running
//  MEASURE | counting samples since the last crossing; locked asserted
module sine_period_meter #(
    parameter int DATA_W     = sine_pkg::DATA_W,
    parameter int MIDPOINT   = sine_pkg::MIDPOINT,
    parameter int HYST       = 4,
    parameter int CNT_W      = 16,
    parameter int MAX_PERIOD = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic [CNT_W-1:0]  period,
    output logic [DATA_W-1:0] vmax,
    output logic [DATA_W-1:0] vmin,
    output logic              meas_valid,
    output logic              locked,
    output logic              timeout
);
    import sine_pkg::*;

    localparam logic [0:0]       ST_SEEK    = 1'(SEEK);
    localparam logic [0:0]       ST_MEASURE = 1'(MEASURE);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             rise_evt;
    logic             at_max;
    logic             rearm;

    assign at_max = (cnt == CNT_MAX);
    // A timeout abandons the cycle; the comparator must see a low sample before re-locking.
    assign rearm  = (state == ST_MEASURE) && sample_valid && !rise_evt && at_max;

    sine_hyst_cmp #(
        .W     (DATA_W),
        .HI_TH (MIDPOINT + HYST),
        .LO_TH (MIDPOINT - HYST)
    ) u_hyst (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (sample_valid),
        .rearm    (rearm),
        .sample   (sample),
        .rise_evt (rise_evt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_SEEK;
            cnt        <= '0;
            period     <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            if (sample_valid) begin
                if (state == ST_SEEK) begin
                    if (rise_evt) begin
                        state  <= ST_MEASURE;
                        cnt    <= CNT_ONE;
                        locked <= 1'b1;
                    end
                end else begin
                    // A crossing on the terminal sample still yields a valid MAX_PERIOD result.
                    if (rise_evt) begin
                        period     <= cnt;
                        meas_valid <= 1'b1;
                        cnt        <= CNT_ONE;
                    end else if (at_max) begin
                        timeout <= 1'b1;
                        state   <= ST_SEEK;
                        locked  <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
            end
        end
    end

`ifdef SINE_METER_PEAK_EN
    logic [DATA_W-1:0] cur_max;
    logic [DATA_W-1:0] cur_min;
    logic [DATA_W-1:0] vmax_q;
    logic [DATA_W-1:0] vmin_q;

    // The running extremes restart at every crossing, including the one that locks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_max <= '0;
            cur_min <= '0;
            vmax_q  <= '0;
            vmin_q  <= '0;
        end else if (sample_valid && rise_evt) begin
            if (state == ST_MEASURE) begin
                vmax_q <= cur_max;
                vmin_q <= cur_min;
            end
            cur_max <= sample;
            cur_min <= sample;
        end else if (sample_valid && (state == ST_MEASURE) && !at_max) begin
            if (sample > cur_max) begin
                cur_max <= sample;
            end
            if (sample < cur_min) begin
                cur_min <= sample;
            end
        end
    end

    assign vmax = vmax_q;
    assign vmin = vmin_q;
`else
    assign vmax = '0;
    assign vmin = '0;
`endif

endmodule

// File: tb/tb_sine_period_meter.sv
// Bench for sine_period_meter: directed waveforms plus random tones against a sample-index model.
module tb_sine_period_meter;

    localparam int MAXP = 300;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [7:0]  sample = 8'd0;
    logic [15:0] period;
    logic [7:0]  vmax;
    logic [7:0]  vmin;
    logic        meas_valid;
    logic        locked;
    logic        timeout;

    always #5 clk = ~clk;

    sine_period_meter #(.MAX_PERIOD(MAXP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .period       (period),
        .vmax         (vmax),
        .vmin         (vmin),
        .meas_valid   (meas_valid),
        .locked       (locked),
        .timeout      (timeout)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit chk_en = 0;

    // Model: positions of accepted samples, index of last crossing, running extremes.
    int m_period, m_vmax, m_vmin, m_idx, m_last, m_cmax, m_cmin;
    bit m_meas, m_to, m_locked, m_hi;

    int n_meas, n_to;
    int meas_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] sine_at(input int i);
        real r;
        r = 127.0 + 127.0 * $sin(6.283185307179586 * real'(i % 256) / 256.0);
        return 8'($rtoi(r + 0.5));
    endfunction

    task automatic model_update(input bit r, input bit v, input logic [7:0] s);
        bit evt;
        m_meas = 0;
        m_to = 0;
        if (!r) begin
            m_period = 0; m_vmax = 0; m_vmin = 0;
            m_locked = 0; m_hi = 1; m_idx = 0; m_last = 0;
            return;
        end
        if (!v) return;
        m_idx++;
        evt = !m_hi && (s >= 131);
        if (s >= 131) m_hi = 1;
        else if (s <= 123) m_hi = 0;
        if (evt) begin
            if (m_locked) begin
                m_period = m_idx - m_last;
                m_meas = 1;
`ifdef SINE_METER_PEAK_EN
                m_vmax = m_cmax;
                m_vmin = m_cmin;
`endif
            end
            m_locked = 1;
            m_last = m_idx;
            m_cmax = s;
            m_cmin = s;
        end else if (m_locked) begin
            if (m_idx - m_last == MAXP) begin
                m_to = 1;
                m_locked = 0;
                m_hi = 1;
            end else begin
                if (s > m_cmax) m_cmax = s;
                if (s < m_cmin) m_cmin = s;
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] s);
        rst_n = r;
        sample_valid = v;
        sample = s;
        @(posedge clk);
        model_update(r, v, s);
        #1;
        cyc++;
        if (meas_valid === 1'b1) begin
            n_meas++;
            meas_cyc.push_back(cyc);
        end
        if (timeout === 1'b1) n_to++;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1, 8'd200);
        step(1'b0, 1'b0, 8'd0);
        n_meas = 0;
        n_to = 0;
        meas_cyc.delete();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("period", period, m_period);
            chk("vmax", vmax, m_vmax);
            chk("vmin", vmin, m_vmin);
            chk("meas_valid", meas_valid, m_meas);
            chk("timeout", timeout, m_to);
            chk("locked", locked, m_locked);
        end
    end

    initial begin
        do_reset();
        chk_en = 1;
        chk("rst_period", period, 0);
        chk("rst_locked", locked, 0);
        chk("rst_meas", meas_valid, 0);

        // 1: continuous sine, four periods
        do_reset();
        for (int i = 0; i < 1024; i++) step(1'b1, 1'b1, sine_at(i));
        chk("t1_meas_count", n_meas, 2);
        chk("t1_period", period, 256);
        chk("t1_model_period", m_period, 256);
        chk("t1_locked", locked, 1);
        if (meas_cyc.size() == 2) chk("t1_spacing", meas_cyc[1] - meas_cyc[0], 256);
`ifdef SINE_METER_PEAK_EN
        chk("t1_vmax", vmax, 254);
        chk("t1_vmin", vmin, 0);
`endif

        // 2: same stream at half rate with junk on invalid cycles
        do_reset();
        for (int i = 0; i < 1024; i++) begin
            step(1'b1, 1'b1, sine_at(i));
            step(1'b1, 1'b0, 8'($urandom));
        end
        chk("t2_meas_count", n_meas, 2);
        chk("t2_period", period, 256);
        if (meas_cyc.size() == 2) chk("t2_spacing", meas_cyc[1] - meas_cyc[0], 512);

        // 3: lock on a square, then sit inside the hysteresis band until timeout
        do_reset();
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 8'd0);
            for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 8'd255);
        end
        chk("t3_pre_period", period, 20);
        for (int k = 1; k <= 400; k++) begin
            step(1'b1, 1'b1, (k % 2 == 1) ? 8'd126 : 8'd129);
            if (k == 290) chk("t3_no_to_yet", n_to, 0);
            if (k == 291) chk("t3_to_pulse", timeout, 1);
        end
        chk("t3_to_count", n_to, 1);
        chk("t3_locked", locked, 0);
        chk("t3_period_held", period, 20);
        chk("t3_meas_count", n_meas, 2);

        // 4: stuck high, then sine from its peak; lock needs a low excursion first
        do_reset();
        for (int k = 0; k < 50; k++) step(1'b1, 1'b1, 8'd255);
        chk("t4_high_unlocked", locked, 0);
        for (int k = 0; k < 300; k++) begin
            step(1'b1, 1'b1, sine_at(64 + k));
            if (k == 193) chk("t4_not_yet", locked, 0);
            if (k == 194) chk("t4_locks", locked, 1);
        end

        // 5: reset mid-period, then keep the sine running
        do_reset();
        for (int i = 0; i < 640; i++) step(1'b1, 1'b1, sine_at(i));
        chk("t5_pre_period", period, 256);
        step(1'b0, 1'b1, sine_at(640));
        chk("t5_rst_period", period, 0);
        chk("t5_rst_locked", locked, 0);
        chk("t5_rst_vmax", vmax, 0);
        n_meas = 0;
        for (int i = 641; i < 1100; i++) begin
            step(1'b1, 1'b1, sine_at(i));
            if (i == 1025) chk("t5_no_meas_yet", n_meas, 0);
        end
        chk("t5_meas_count", n_meas, 1);
        chk("t5_period", period, 256);

        // 6: full-scale square, 10 samples per level
        do_reset();
        for (int p = 0; p < 6; p++) begin
            for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 8'd0);
            for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 8'd255);
        end
        chk("t6_meas_count", n_meas, 5);
        chk("t6_period", period, 20);
        if (meas_cyc.size() >= 2) chk("t6_spacing", meas_cyc[1] - meas_cyc[0], 20);
`ifdef SINE_METER_PEAK_EN
        chk("t6_vmax", vmax, 255);
        chk("t6_vmin", vmin, 0);
`else
        chk("t6_vmax", vmax, 0);
        chk("t6_vmin", vmin, 0);
`endif

        // 7: random tones, gaps, noise and occasional resets
        do_reset();
        begin
            int steps = 0;
            while (steps < 15000) begin
                int h = $urandom_range(2, 200);
                int lo = $urandom_range(0, 123);
                int hi = $urandom_range(131, 255);
                for (int ph = 0; ph < 2; ph++) begin
                    for (int k = 0; k < h; k++) begin
                        logic [7:0] s = (ph == 0) ? 8'(lo) : 8'(hi);
                        bit v = ($urandom_range(0, 3) != 0);
                        bit r = ($urandom_range(0, 499) != 0);
                        if ($urandom_range(0, 7) == 0) s = 8'($urandom_range(0, 255));
                        step(r, v, s);
                        steps++;
                    end
                end
            end
        end

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
